// File: rtl/flop_pkg.sv
// Shared constants, field layout, FSM state type and helpers for the
// 13-bit packed-float to 16-bit integer converter.
package flop_pkg;

    localparam int FLOP_W   = 13;
    localparam int EXP_W    = 8;
    localparam int MANT_W   = 4;
    localparam int EXP_BIAS = 127;
    localparam int INT_W    = 16;

    localparam int SIGN_BIT = 12;
    localparam int EXP_MSB  = 11;
    localparam int EXP_LSB  = 4;
    localparam int MANT_MSB = 3;
    localparam int MANT_LSB = 0;

    localparam int SIG_W   = MANT_W + 1;
    localparam int SHAMT_W = 4;

    // Exponent at which the 5-bit significand {1,mmmm} is already an integer.
    localparam int SHIFT_PIVOT = EXP_BIAS + MANT_W;
    // Largest unbiased exponent whose result still fits a signed INT_W value.
    localparam int MAX_UNSAT_E = INT_W - 2;

    localparam logic [INT_W-1:0] INT_MAX = 16'h7FFF;
    localparam logic [INT_W-1:0] INT_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } flop_fields_t;

    function automatic flop_fields_t split_flop(input logic [FLOP_W-1:0] f);
        flop_fields_t r;
        r.sign = f[SIGN_BIT];
        r.exp  = f[EXP_MSB:EXP_LSB];
        r.mant = f[MANT_MSB:MANT_LSB];
        return r;
    endfunction

    function automatic logic [INT_W-1:0] apply_sign(input logic [INT_W-1:0] mag,
                                                    input logic             neg);
        return neg ? (INT_W'(0) - mag) : mag;
    endfunction

endpackage

// File: rtl/flop_to_int_if.sv
// Operand/result handshake bundle for flop_to_int; master drives operands
// and consumes results, slave is the converter.
interface flop_to_int_if;

    logic [flop_pkg::FLOP_W-1:0] in_flop;
    logic                        in_valid;
    logic                        in_ready;
    logic [flop_pkg::INT_W-1:0]  out_int;
    logic                        out_sat;
    logic                        out_inexact;
    logic                        out_valid;
    logic                        out_ready;

    modport master (
        output in_flop,
        output in_valid,
        input  in_ready,
        input  out_int,
        input  out_sat,
        input  out_inexact,
        input  out_valid,
        output out_ready
    );

    modport slave (
        input  in_flop,
        input  in_valid,
        output in_ready,
        output out_int,
        output out_sat,
        output out_inexact,
        output out_valid,
        input  out_ready
    );

endinterface

// File: rtl/flop_unpack.sv
// Combinational field split and classification of a packed float:
// zero, underflow, saturation, shift direction and shift amount.
module flop_unpack
    import flop_pkg::*;
(
    input  logic [FLOP_W-1:0]  flop,
    output logic               sign,
    output logic [MANT_W-1:0]  mant,
    output logic               is_zero,
    output logic               is_under,
    output logic               is_over,
    output logic               shift_left,
    output logic [SHAMT_W-1:0] shamt
);

    localparam logic [EXP_W-1:0] EXP_UNDER = EXP_W'(EXP_BIAS - 1);
    localparam logic [EXP_W-1:0] EXP_OVER  = EXP_W'(EXP_BIAS + MAX_UNSAT_E);
    localparam logic [EXP_W-1:0] EXP_PIVOT = EXP_W'(SHIFT_PIVOT);

    flop_fields_t fields;
    logic         is_special;

    assign fields     = split_flop(flop);
    assign sign       = fields.sign;
    assign mant       = fields.mant;

    // Values below one half truncate (or round) to zero no matter the fraction.
    assign is_zero    = (fields.exp == '0);
    assign is_under   = !is_zero && (fields.exp < EXP_UNDER);
    assign is_over    = (fields.exp > EXP_OVER);
    assign is_special = is_zero || is_under || is_over;
    assign shift_left = (fields.exp > EXP_PIVOT);

    always_comb begin
        shamt = '0;
        if (!is_special) begin
            if (shift_left) begin
                shamt = SHAMT_W'(fields.exp - EXP_PIVOT);
            end else begin
                shamt = SHAMT_W'(EXP_PIVOT - fields.exp);
            end
        end
    end

endmodule

// File: rtl/flop_to_int.sv
// Sequential packed-float to integer converter: one shift bit per cycle.
// Optional round-half-to-even when FLOP_TO_INT_ROUND_EN is defined.
module flop_to_int
    import flop_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    flop_to_int_if.slave  bus
);

    state_t               state_q, state_d;
    logic [INT_W-1:0]     mag_q, mag_d;
    logic [SHAMT_W-1:0]   shamt_q, shamt_d;
    logic                 left_q, left_d;
    logic                 sign_q, sign_d;
    logic                 guard_q, guard_d;
    logic                 sticky_q, sticky_d;
    logic [INT_W-1:0]     out_int_q, out_int_d;
    logic                 out_sat_q, out_sat_d;
    logic                 out_inexact_q, out_inexact_d;
    logic                 out_valid_q, out_valid_d;

    logic                 u_sign;
    logic [MANT_W-1:0]    u_mant;
    logic                 u_zero;
    logic                 u_under;
    logic                 u_over;
    logic                 u_left;
    logic [SHAMT_W-1:0]   u_shamt;

    logic [INT_W-1:0]     mag_load;
    logic [INT_W-1:0]     mag_step;
    logic                 guard_step;
    logic                 sticky_step;
    logic [INT_W-1:0]     mag_fin;
    logic                 guard_fin;
    logic                 sticky_fin;
    logic                 sign_fin;
    logic [INT_W-1:0]     mag_rnd;
    logic [INT_W-1:0]     result_fin;

    flop_unpack u_unpack (
        .flop       (bus.in_flop),
        .sign       (u_sign),
        .mant       (u_mant),
        .is_zero    (u_zero),
        .is_under   (u_under),
        .is_over    (u_over),
        .shift_left (u_left),
        .shamt      (u_shamt)
    );

    assign mag_load = INT_W'({1'b1, u_mant});

    // Right shifts push the departing bit into guard and fold the old guard into sticky.
    always_comb begin
        mag_step    = left_q ? {mag_q[INT_W-2:0], 1'b0} : {1'b0, mag_q[INT_W-1:1]};
        guard_step  = left_q ? guard_q  : mag_q[0];
        sticky_step = left_q ? sticky_q : (sticky_q | guard_q);
    end

    always_comb begin
        mag_fin    = mag_step;
        guard_fin  = guard_step;
        sticky_fin = sticky_step;
        sign_fin   = sign_q;
        if (state_q == IDLE) begin
            mag_fin    = mag_load;
            guard_fin  = 1'b0;
            sticky_fin = 1'b0;
            sign_fin   = u_sign;
        end
    end

`ifdef FLOP_TO_INT_ROUND_EN
    assign mag_rnd = mag_fin + INT_W'(guard_fin && (sticky_fin || mag_fin[0]));
`else
    assign mag_rnd = mag_fin;
`endif

    assign result_fin = apply_sign(mag_rnd, sign_fin);

    always_comb begin
        state_d       = state_q;
        mag_d         = mag_q;
        shamt_d       = shamt_q;
        left_d        = left_q;
        sign_d        = sign_q;
        guard_d       = guard_q;
        sticky_d      = sticky_q;
        out_int_d     = out_int_q;
        out_sat_d     = out_sat_q;
        out_inexact_d = out_inexact_q;
        out_valid_d   = out_valid_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                if (bus.in_valid) begin
                    mag_d    = mag_load;
                    shamt_d  = u_shamt;
                    left_d   = u_left;
                    sign_d   = u_sign;
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    if (u_zero || u_under) begin
                        state_d       = DONE;
                        out_int_d     = '0;
                        out_sat_d     = 1'b0;
                        out_inexact_d = u_under;
                    end else if (u_over) begin
                        state_d       = DONE;
                        out_int_d     = u_sign ? INT_MIN : INT_MAX;
                        out_sat_d     = 1'b1;
                        out_inexact_d = 1'b0;
                    end else if (u_shamt == '0) begin
                        state_d       = DONE;
                        out_int_d     = result_fin;
                        out_sat_d     = 1'b0;
                        out_inexact_d = 1'b0;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end

            SHIFT: begin
                mag_d    = mag_step;
                guard_d  = guard_step;
                sticky_d = sticky_step;
                shamt_d  = shamt_q - 1'b1;
                if (shamt_q == SHAMT_W'(1)) begin
                    state_d       = DONE;
                    out_int_d     = result_fin;
                    out_sat_d     = 1'b0;
                    out_inexact_d = guard_step | sticky_step;
                end
            end

            // out_valid trails entry into DONE by one cycle and drops on the handshake.
            DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mag_q         <= '0;
            shamt_q       <= '0;
            left_q        <= 1'b0;
            sign_q        <= 1'b0;
            guard_q       <= 1'b0;
            sticky_q      <= 1'b0;
            out_int_q     <= '0;
            out_sat_q     <= 1'b0;
            out_inexact_q <= 1'b0;
            out_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            shamt_q       <= shamt_d;
            left_q        <= left_d;
            sign_q        <= sign_d;
            guard_q       <= guard_d;
            sticky_q      <= sticky_d;
            out_int_q     <= out_int_d;
            out_sat_q     <= out_sat_d;
            out_inexact_q <= out_inexact_d;
            out_valid_q   <= out_valid_d;
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_int     = out_int_q;
    assign bus.out_sat     = out_sat_q;
    assign bus.out_inexact = out_inexact_q;
    assign bus.out_valid   = out_valid_q;

endmodule

// File: tb/tb_flop_to_int.sv
// Scoreboard bench for flop_to_int: expectations queued at drive time,
// popped and compared when out_valid appears. Honours FLOP_TO_INT_ROUND_EN.
module tb_flop_to_int;

    typedef struct {
        string       name;
        logic [15:0] val;
        logic        sat;
        logic        inexact;
        int          lat;
    } expect_t;

    logic    clk;
    logic    rst_n;
    int      testCount;
    int      failCount;
    expect_t sbQueue[$];

    flop_to_int_if bus();

    flop_to_int dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        testCount++;
        if (got !== want) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Independent reference: integer arithmetic on the significand.
    task automatic modelConvert(input logic [12:0] f, output logic [15:0] val,
                                output logic sat, output logic inx, output int lat);
        int e;
        int sig;
        int mag;
        int sh;
        int rem;
        int half;
        e   = int'(f[11:4]) - 127;
        sig = 16 + int'(f[3:0]);
        val = 16'h0000;
        sat = 1'b0;
        inx = 1'b0;
        lat = 1;
        half = 0;
        if (f[11:4] == 8'h00) begin
            val = 16'h0000;
        end else if (e > 14) begin
            sat = 1'b1;
            val = f[12] ? 16'h8000 : 16'h7FFF;
        end else if (e < -1) begin
            inx = 1'b1;
        end else begin
            if (e >= 4) begin
                mag = sig << (e - 4);
                lat = e - 4 + 1;
            end else begin
                sh  = 4 - e;
                mag = sig >> sh;
                rem = sig - (mag << sh);
                inx = (rem != 0);
                lat = sh + 1;
`ifdef FLOP_TO_INT_ROUND_EN
                half = 1 << (sh - 1);
                if (rem > half || (rem == half && (mag % 2) == 1)) mag = mag + 1;
`endif
            end
            if (f[12]) mag = -mag;
            val = mag[15:0];
        end
    endtask

    task automatic applyStimulus(input string name, input logic [12:0] flop,
                                 input logic [15:0] val, input logic sat,
                                 input logic inx, input int lat, input bit record);
        expect_t item;
        int      waitCycles;
        if (record) begin
            item.name    = name;
            item.val     = val;
            item.sat     = sat;
            item.inexact = inx;
            item.lat     = lat;
            sbQueue.push_back(item);
        end
        waitCycles = 0;
        while (bus.in_ready !== 1'b1 && waitCycles < 50) begin
            @(posedge clk);
            #1;
            waitCycles++;
        end
        checkOutput({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_flop  = flop;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic collectResult(input int holdCycles, input bit noisy);
        expect_t item;
        int      cycles;
        cycles = 0;
        while (cycles < 40) begin
            if (noisy) begin
                bus.in_flop  = 13'($urandom);
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (bus.out_valid === 1'b1) break;
        end
        bus.in_valid = 1'b0;
        if (sbQueue.size() == 0) begin
            checkOutput("sb_underflow", 32'd0, 32'd1);
            return;
        end
        item = sbQueue.pop_front();
        checkOutput({item.name, "_valid"},   32'(bus.out_valid),   32'd1);
        checkOutput({item.name, "_latency"}, 32'(cycles),          32'(item.lat));
        checkOutput({item.name, "_int"},     32'(bus.out_int),     32'(item.val));
        checkOutput({item.name, "_sat"},     32'(bus.out_sat),     32'(item.sat));
        checkOutput({item.name, "_inexact"}, 32'(bus.out_inexact), 32'(item.inexact));
        checkOutput({item.name, "_busy"},    32'(bus.in_ready),    32'd0);
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput({item.name, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({item.name, "_hold_int"},   32'(bus.out_int),   32'(item.val));
            checkOutput({item.name, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput({item.name, "_drop_valid"}, 32'(bus.out_valid), 32'd0);
        checkOutput({item.name, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
    endtask

    task automatic runModel(input string name, input logic [12:0] f, input int hold, input bit noisy);
        logic [15:0] val;
        logic        sat;
        logic        inx;
        int          lat;
        modelConvert(f, val, sat, inx, lat);
        applyStimulus(name, f, val, sat, inx, lat, 1'b1);
        collectResult(hold, noisy);
    endtask

    initial begin
        int  sawValid;
        logic [12:0] rf;
        testCount     = 0;
        failCount     = 0;
        bus.in_flop   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_valid",   32'(bus.out_valid),   32'd0);
        checkOutput("reset_int",     32'(bus.out_int),     32'd0);
        checkOutput("reset_sat",     32'(bus.out_sat),     32'd0);
        checkOutput("reset_inexact", 32'(bus.out_inexact), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);

`ifdef FLOP_TO_INT_ROUND_EN
        applyStimulus("pos_1p5", 13'h07F8, 16'h0002, 1'b0, 1'b1, 5, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("neg_1p5", 13'h17F8, 16'hFFFE, 1'b0, 1'b1, 5, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("half_0p75", 13'h07E8, 16'h0001, 1'b0, 1'b1, 6, 1'b1);
        collectResult(0, 1'b0);
`else
        applyStimulus("pos_1p5", 13'h07F8, 16'h0001, 1'b0, 1'b1, 5, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("neg_1p5", 13'h17F8, 16'hFFFF, 1'b0, 1'b1, 5, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("half_0p75", 13'h07E8, 16'h0000, 1'b0, 1'b1, 6, 1'b1);
        collectResult(0, 1'b0);
`endif
        applyStimulus("tie_2p5",   13'h0804, 16'h0002, 1'b0, 1'b1, 4, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("half_0p5",  13'h07E0, 16'h0000, 1'b0, 1'b1, 6, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("neg_3_hold", 13'h1808, 16'hFFFD, 1'b0, 1'b0, 4, 1'b1);
        collectResult(10, 1'b0);
        applyStimulus("neg_3_noisy", 13'h1808, 16'hFFFD, 1'b0, 1'b0, 4, 1'b1);
        collectResult(0, 1'b1);
        // 1.9375 * 2^14 is encoded with biased exponent 141, i.e. 13'h08DF.
        applyStimulus("max_unsat", 13'h08DF, 16'd31744, 1'b0, 1'b0, 11, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("sat_e15",   13'h08EF, 16'h7FFF, 1'b1, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("sat_pos",   13'h08F0, 16'h7FFF, 1'b1, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("sat_neg",   13'h18F0, 16'h8000, 1'b1, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("zero_pos",  13'h0000, 16'h0000, 1'b0, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("zero_neg",  13'h1000, 16'h0000, 1'b0, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("under_e-2", 13'h07D0, 16'h0000, 1'b0, 1'b1, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("noshift",   13'h0835, 16'd21,   1'b0, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);
        applyStimulus("noshift_n", 13'h1835, 16'hFFEB, 1'b0, 1'b0, 1, 1'b1);
        collectResult(0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rf = {1'($urandom), 8'($urandom_range(120, 146)), 4'($urandom)};
            runModel($sformatf("rand%0d_%0h", i, rf), rf, 0, 1'b0);
        end

        applyStimulus("abort", 13'h1808, 16'h0000, 1'b0, 1'b0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("abort_int",   32'(bus.out_int),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) sawValid = 1;
        end
        checkOutput("abort_no_result", 32'(sawValid), 32'd0);
        checkOutput("abort_in_ready",  32'(bus.in_ready), 32'd1);

        runModel("after_abort", 13'h0808, 0, 1'b0);
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
